ppg_led_scheduler: RTL and testbench

- Time-multiplexes the shared analog front-end between RED and IR LED channels, plus an optional ambient (both LEDs off) phase.
- Each frame: applies the per-channel LED drive, DC compensation and PGA gain; waits for analog settling; triggers one ADC conversion; captures the result.
- Sits between the calibration controller, which supplies the per-channel settings, and the FIR filter, which consumes red_sample/ir_sample.

---
 rtl/ppg_led_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_ppg_led_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppg_led_scheduler.sv
// ppg_led_scheduler
// Time-multiplexes the shared PPG analog front-end between the RED and IR LED
// channels, with an optional ambient (both LEDs off) phase. Each frame applies
// the per-channel drive, DC compensation and gain, waits for settling, runs one
// ADC conversion per phase and publishes both samples together.
//
// Build option: define AMBIENT_SUB_EN to run the ambient phase and subtract
// the ambient reading (clamped at zero) from both channel samples. Without it
// the ambient phase is skipped and raw samples are published.

module ppg_led_scheduler #(
    parameter int SETTLE_CYC  = 16,
    parameter int FRAME_CYC   = 256,
    parameter int ADC_TIMEOUT = 64,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [3:0]        red_drive,
    input  logic [6:0]        red_dc,
    input  logic [3:0]        red_gain,
    input  logic [3:0]        ir_drive,
    input  logic [6:0]        ir_dc,
    input  logic [3:0]        ir_gain,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_done,
    output logic              adc_start,
    output logic              LED_RED,
    output logic              LED_IR,
    output logic [3:0]        LED_Drive,
    output logic [6:0]        DC_Comp,
    output logic [3:0]        PGA_Gain,
    output logic [DATA_W-1:0] red_sample,
    output logic [DATA_W-1:0] ir_sample,
    output logic              sample_valid,
    output logic              adc_err
);

    localparam int PH_MAX = (SETTLE_CYC > ADC_TIMEOUT) ? SETTLE_CYC : ADC_TIMEOUT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int FR_W   = $clog2(FRAME_CYC + 1);

    localparam logic [PH_W-1:0] SETTLE_LAST  = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(ADC_TIMEOUT - 1);
    localparam logic [FR_W-1:0] FRAME_LAST   = FR_W'(FRAME_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        RED_SET,
        RED_CONV,
        AMB_SET,
        AMB_CONV,
        IR_SET,
        IR_CONV,
        WAIT_FRAME
    } state_t;

    state_t state;
    state_t state_n;

    logic [PH_W-1:0]   phase_cnt;
    logic [FR_W-1:0]   frame_cnt;
    logic              in_set;
    logic              in_conv;
    logic              conv_end;
    logic              tmo_hit;
    logic              frame_start;
    logic [DATA_W-1:0] conv_val;

    // IR settings are shadowed at frame start; RED settings are latched
    // straight into the output registers on the same edge and held there.
    logic [3:0]        ir_drive_sh;
    logic [6:0]        ir_dc_sh;
    logic [3:0]        ir_gain_sh;
    logic [DATA_W-1:0] red_raw;
`ifdef AMBIENT_SUB_EN
    logic [DATA_W-1:0] amb_raw;

    // Ambient removal: 9-bit signed difference, negative results clamp to zero.
    function automatic logic [DATA_W-1:0] sub_clamp(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DATA_W] ? '0 : d[DATA_W-1:0];
    endfunction
`endif

    // Next-state decode plus conversion-completion and frame-start qualifiers.
    always_comb begin
        state_n     = state;
        in_set      = (state == RED_SET) || (state == AMB_SET) || (state == IR_SET);
        in_conv     = (state == RED_CONV) || (state == AMB_CONV) || (state == IR_CONV);
        tmo_hit     = in_conv && !adc_done && (phase_cnt == TIMEOUT_LAST);
        conv_end    = in_conv && (adc_done || (phase_cnt == TIMEOUT_LAST));
        conv_val    = adc_done ? adc_data : '0;
        case (state)
            IDLE:       if (enable) state_n = RED_SET;
            RED_SET:    if (phase_cnt == SETTLE_LAST) state_n = RED_CONV;
            RED_CONV: begin
                if (conv_end) begin
`ifdef AMBIENT_SUB_EN
                    state_n = AMB_SET;
`else
                    state_n = IR_SET;
`endif
                end
            end
            AMB_SET:    if (phase_cnt == SETTLE_LAST) state_n = AMB_CONV;
            AMB_CONV:   if (conv_end) state_n = IR_SET;
            IR_SET:     if (phase_cnt == SETTLE_LAST) state_n = IR_CONV;
            IR_CONV:    if (conv_end) state_n = WAIT_FRAME;
            WAIT_FRAME: if (frame_cnt == FRAME_LAST) state_n = enable ? RED_SET : IDLE;
            default:    state_n = IDLE;
        endcase
        frame_start = (state_n == RED_SET) && ((state == IDLE) || (state == WAIT_FRAME));
    end

    // State register, per-phase counter and saturating frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                phase_cnt <= '0;
            end else if (in_set || in_conv) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if (frame_start) begin
                frame_cnt <= '0;
            end else if (frame_cnt != FRAME_LAST) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Frame-start shadow of IR settings and per-phase raw captures.
    always_ff @(posedge clk) begin
        if (frame_start) begin
            ir_drive_sh <= ir_drive;
            ir_dc_sh    <= ir_dc;
            ir_gain_sh  <= ir_gain;
        end
        if ((state == RED_CONV) && conv_end) red_raw <= conv_val;
`ifdef AMBIENT_SUB_EN
        if ((state == AMB_CONV) && conv_end) amb_raw <= conv_val;
`endif
    end

    // Front-end controls, ADC request, published samples and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_start    <= 1'b0;
            LED_RED      <= 1'b0;
            LED_IR       <= 1'b0;
            LED_Drive    <= '0;
            DC_Comp      <= '0;
            PGA_Gain     <= '0;
            red_sample   <= '0;
            ir_sample    <= '0;
            sample_valid <= 1'b0;
            adc_err      <= 1'b0;
        end else begin
            adc_start <= (state_n != state) &&
                         ((state_n == RED_CONV) || (state_n == AMB_CONV) || (state_n == IR_CONV));
            if (state_n != state) begin
                case (state_n)
                    RED_SET: begin
                        LED_RED   <= 1'b1;
                        LED_IR    <= 1'b0;
                        LED_Drive <= red_drive;
                        DC_Comp   <= red_dc;
                        PGA_Gain  <= red_gain;
                    end
                    AMB_SET: begin
                        LED_RED   <= 1'b0;
                        LED_IR    <= 1'b0;
                        LED_Drive <= '0;
                    end
                    IR_SET: begin
                        LED_RED   <= 1'b0;
                        LED_IR    <= 1'b1;
                        LED_Drive <= ir_drive_sh;
                        DC_Comp   <= ir_dc_sh;
                        PGA_Gain  <= ir_gain_sh;
                    end
                    IDLE, WAIT_FRAME: begin
                        LED_RED <= 1'b0;
                        LED_IR  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            sample_valid <= (state == IR_CONV) && conv_end;
            if ((state == IR_CONV) && conv_end) begin
`ifdef AMBIENT_SUB_EN
                red_sample <= sub_clamp(red_raw, amb_raw);
                ir_sample  <= sub_clamp(conv_val, amb_raw);
`else
                red_sample <= red_raw;
                ir_sample  <= conv_val;
`endif
            end
            if (tmo_hit) adc_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppg_led_scheduler.sv
// Directed bench for ppg_led_scheduler: a table of per-frame vectors (settings,
// ADC responses and hand-computed results) run back to back, plus hand-written
// sequences for enable drop/re-assert and reset during a conversion.

module tb_ppg_led_scheduler;

    localparam int SETTLE = 4;
    localparam int FRAME  = 64;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] red_drive = '0;
    logic [6:0] red_dc = '0;
    logic [3:0] red_gain = '0;
    logic [3:0] ir_drive = '0;
    logic [6:0] ir_dc = '0;
    logic [3:0] ir_gain = '0;
    logic [7:0] adc_data = '0;
    logic       adc_done = 1'b0;
    logic       adc_start, LED_RED, LED_IR, sample_valid, adc_err;
    logic [3:0] LED_Drive, PGA_Gain;
    logic [6:0] DC_Comp;
    logic [7:0] red_sample, ir_sample;

    ppg_led_scheduler #(
        .SETTLE_CYC (SETTLE),
        .FRAME_CYC  (FRAME),
        .ADC_TIMEOUT(TMO),
        .DATA_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .red_drive   (red_drive),
        .red_dc      (red_dc),
        .red_gain    (red_gain),
        .ir_drive    (ir_drive),
        .ir_dc       (ir_dc),
        .ir_gain     (ir_gain),
        .adc_data    (adc_data),
        .adc_done    (adc_done),
        .adc_start   (adc_start),
        .LED_RED     (LED_RED),
        .LED_IR      (LED_IR),
        .LED_Drive   (LED_Drive),
        .DC_Comp     (DC_Comp),
        .PGA_Gain    (PGA_Gain),
        .red_sample  (red_sample),
        .ir_sample   (ir_sample),
        .sample_valid(sample_valid),
        .adc_err     (adc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int space_valid = 0;
    int prev_start  = 0;
    int exp_space   = 0;

    typedef struct {
        int r_drv; int r_dc; int r_gain;
        int i_drv; int i_dc; int i_gain;
        int r_adc; int a_adc; int i_adc;
        int r_dly; int a_dly; int i_dly;     // adc_done delay after adc_start, -1 = never
        int mid_rdc;                         // red_dc written during RED_SET, -1 = none
        int drop_en;                         // drop enable in the first RED_SET cycle
        int exp_err;
        int r_raw; int i_raw;                // expected samples, raw build
        int r_sub; int i_sub;                // expected samples, ambient-subtract build
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] outs_bus();
        return {adc_start, LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain,
                red_sample, ir_sample, sample_valid, adc_err};
    endfunction

    task automatic set_cfg(input vec_t v);
        red_drive = 4'(v.r_drv);
        red_dc    = 7'(v.r_dc);
        red_gain  = 4'(v.r_gain);
        ir_drive  = 4'(v.i_drv);
        ir_dc     = 7'(v.i_dc);
        ir_gain   = 4'(v.i_gain);
    endtask

    // Runs one frame: acts as the ADC, watches the LED/phase behaviour and checks
    // the published samples. Called at a negedge; returns at the sample_valid cycle.
    task automatic run_frame(input vec_t v, input int idx);
        int extra, red_n, ir_n, bad, both, gap, exp_gap, exp_conv;
        int red_started, ir_started, ir_seen, ir_k, sv_k, start;
        int pend, pend_cnt, pend_ch, dly;
        string tag;
        tag = $sformatf("v%0d", idx);
        extra = 0; red_n = 0; ir_n = 0; bad = 0; both = 0; gap = 0;
        red_started = 0; ir_started = 0; ir_seen = 0; ir_k = -1; sv_k = -1;
        pend = 0; pend_cnt = 0; pend_ch = 0;
        set_cfg(v);
        enable   = 1'b1;
        adc_done = 1'b0;
        for (int w = 0; w < 300 && !LED_RED; w++) begin
            @(negedge clk);
            if (sample_valid && !LED_RED) extra++;
        end
        chk({tag, "_frame_start"}, int'(LED_RED), 1);
        if (!LED_RED) return;
        chk({tag, "_prev_sv_single_pulse"}, extra, 0);
        start = cyc;
        if (space_valid != 0) chk({tag, "_frame_spacing"}, start - prev_start, exp_space);
        for (int k = 0; k < 400; k++) begin
            if (k == 0 && v.drop_en != 0) enable = 1'b0;
            if (k == 1 && v.mid_rdc >= 0) red_dc = 7'(v.mid_rdc);
            if (LED_RED && LED_IR) both++;
            if (LED_IR) ir_seen = 1;
            if (LED_RED && red_started == 0 && !adc_start) begin
                red_n++;
                if (int'(LED_Drive) != v.r_drv || int'(DC_Comp) != v.r_dc ||
                    int'(PGA_Gain) != v.r_gain) bad++;
            end
            if (LED_IR && ir_started == 0 && !adc_start) begin
                ir_n++;
                if (int'(LED_Drive) != v.i_drv || int'(DC_Comp) != v.i_dc ||
                    int'(PGA_Gain) != v.i_gain) bad++;
            end
            if (red_started != 0 && !LED_RED && !LED_IR && ir_seen == 0) begin
                gap++;
                if (LED_Drive != 4'd0 || int'(DC_Comp) != v.r_dc ||
                    int'(PGA_Gain) != v.r_gain) bad++;
            end
            adc_done = 1'b0;
            if (adc_start) begin
                pend_ch = LED_RED ? 0 : (LED_IR ? 2 : 1);
                if (pend_ch == 0) red_started = 1;
                if (pend_ch == 2) begin
                    ir_started = 1;
                    ir_k = k;
                end
                dly = (pend_ch == 0) ? v.r_dly : ((pend_ch == 1) ? v.a_dly : v.i_dly);
                pend = (dly >= 0) ? 1 : 0;
                pend_cnt = dly;
            end
            if (pend != 0) begin
                if (pend_cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = 8'((pend_ch == 0) ? v.r_adc : ((pend_ch == 1) ? v.a_adc : v.i_adc));
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (sample_valid) begin
                sv_k = k;
                break;
            end
            @(negedge clk);
        end
        adc_done = 1'b0;
        chk({tag, "_sample_valid_seen"}, (sv_k >= 0) ? 1 : 0, 1);
        if (sv_k < 0) return;
`ifdef AMBIENT_SUB_EN
        exp_gap = SETTLE + v.a_dly + 1;
`else
        exp_gap = 0;
`endif
        exp_conv = (v.i_dly < 0) ? TMO : v.i_dly + 1;
        chk({tag, "_red_settle_cycles"}, red_n, SETTLE);
        chk({tag, "_ir_settle_cycles"}, ir_n, SETTLE);
        chk({tag, "_drive_dc_gain_errs"}, bad, 0);
        chk({tag, "_both_leds_on"}, both, 0);
        chk({tag, "_ambient_gap"}, gap, exp_gap);
        chk({tag, "_ir_conv_len"}, sv_k - ir_k, exp_conv);
`ifdef AMBIENT_SUB_EN
        chk({tag, "_red_sample"}, int'(red_sample), v.r_sub);
        chk({tag, "_ir_sample"}, int'(ir_sample), v.i_sub);
`else
        chk({tag, "_red_sample"}, int'(red_sample), v.r_raw);
        chk({tag, "_ir_sample"}, int'(ir_sample), v.i_raw);
`endif
        chk({tag, "_adc_err"}, int'(adc_err), v.exp_err);
        if (v.drop_en != 0) begin
            space_valid = 0;
        end else begin
            space_valid = 1;
            prev_start  = start;
            exp_space   = (sv_k <= FRAME - 1) ? FRAME : sv_k + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int act, found;
        //             red drv/dc/gain  ir drv/dc/gain  adc R/A/I     dly R/A/I  mid drop err  raw R/I   sub R/I
        vecs[0] = '{10, 40, 3,   5, 20, 7,    200, 30, 150,  3, 3, 3,   -1, 0, 0,  200, 150,  170, 120};
        vecs[1] = '{10, 41, 3,   9, 100, 15,  200, 30, 20,   0, 1, 0,   99, 0, 0,  200, 20,   170, 0};
        vecs[2] = '{15, 127, 15, 1, 1, 1,     255, 255, 0,   1, 2, 5,   -1, 0, 0,  255, 0,    0, 0};
        vecs[3] = '{3, 41, 2,    6, 70, 4,    77, 10, 0,     2, 0, -1,  -1, 0, 1,  77, 0,     67, 0};
        vecs[4] = '{2, 5, 6,     12, 64, 8,   7, 0, 255,     4, 4, 4,   -1, 0, 1,  7, 255,    7, 255};
        vecs[5] = '{4, 50, 1,    8, 60, 2,    100, 50, 60,   1, 1, 1,   -1, 1, 1,  100, 60,   50, 10};
        vecs[6] = '{11, 33, 5,   13, 66, 9,   128, 28, 129,  2, 2, 2,   -1, 0, 1,  128, 129,  100, 101};
        vecs[7] = '{1, 2, 3,     4, 5, 6,     90, 9, 45,     3, 3, 3,   -1, 0, 0,  90, 45,    81, 36};

        repeat (3) @(negedge clk);
        chk("reset_outputs_set_bits", $countones(outs_bus()), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_leds_without_enable", int'(LED_RED | LED_IR), 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // enable was dropped in vector 5: frame finished, block must sit idle
        act = 0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (LED_RED || LED_IR || sample_valid || adc_start) act++;
        end
        chk("idle_after_enable_drop", act, 0);
        set_cfg(vecs[6]);
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_red_one_cycle", int'(LED_RED), 1);
        chk("reenable_drive", int'(LED_Drive), vecs[6].r_drv);
        run_frame(vecs[6], 6);

        // reset in the middle of RED_CONV
        set_cfg(vecs[7]);
        found = 0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (adc_start && LED_RED) begin
                found = 1;
                break;
            end
        end
        chk("rst_reached_red_conv", found, 1);
        #2 rst = 1'b1;
        #1 chk("rst_led_red_async", int'(LED_RED), 0);
        chk("rst_mid_outputs_set_bits", $countones(outs_bus()), 0);
        act = 0;
        repeat (3) begin
            @(negedge clk);
            if (sample_valid || LED_RED || LED_IR) act++;
        end
        chk("rst_held_quiet", act, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_restart", int'(LED_RED), 1);
        chk("rst_release_dc", int'(DC_Comp), vecs[7].r_dc);
        space_valid = 0;
        run_frame(vecs[7], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
